// File: rtl/hand_centroid_tracker_pkg.sv
// Shared constants, FSM encoding and quotient helper for the hand centroid tracker.
package hand_track_pkg;

   localparam int H_ACTIVE_DEF   = 638;
   localparam int V_ACTIVE_DEF   = 478;
   localparam int MIN_PIXELS_DEF = 2000;
   localparam int CNT_W          = 19;
   localparam int SUM_W          = 28;
   localparam int COORD_W        = 10;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SNAP  = 3'd1;
   localparam logic [2:0] ST_DIV_X = 3'd2;
   localparam logic [2:0] ST_DIV_Y = 3'd3;
   localparam logic [2:0] ST_PUB   = 3'd4;

   // A mean coordinate always fits COORD_W bits; the clamp only matters for the
   // all-ones divide-by-zero quotient, which the caller overrides anyway.
   function automatic logic [COORD_W-1:0] to_coord(input logic [SUM_W-1:0] q);
      if (|q[SUM_W-1:COORD_W])
         to_coord = '1;
      else
         to_coord = q[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/hand_centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle. done pulses DVD_W+1 cycles
// after start; a zero divisor yields an all-ones quotient.
module seq_divider
   import hand_track_pkg::*;
#(
   parameter int DVD_W = SUM_W,
   parameter int DVS_W = CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             done
);

   localparam int BC_W = $clog2(DVD_W + 1);

   logic [DVD_W-1:0] quo;
   logic [DVS_W:0]   rem;
   logic [DVS_W-1:0] dvs;
   logic [BC_W-1:0]  bit_cnt;
   logic             busy;
   logic [DVS_W+1:0] rem_sh;
   logic [DVS_W+1:0] diff;
   logic             ge;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      rem_sh = {rem, quo[DVD_W-1]};
      diff   = rem_sh - {2'b00, dvs};
      ge     = ~diff[DVS_W+1];
   end

   // Shift/subtract iteration; bit_cnt counts remaining quotient bits down to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         bit_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            bit_cnt <= BC_W'(DVD_W);
            busy    <= 1'b1;
         end else if (busy) begin
            quo     <= {quo[DVD_W-2:0], ge};
            rem     <= ge ? diff[DVS_W:0] : rem_sh[DVS_W:0];
            bit_cnt <= bit_cnt - BC_W'(1);
            if (bit_cnt == BC_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/hand_centroid_tracker.sv
// Hand centroid tracker: accumulates mask pixel count and coordinate sums per
// frame, divides at frame end and publishes one centroid per frame.
// Optional bounding-box tracking is enabled by defining HAND_BBOX_EN.
//
// state    | meaning
// IDLE     | waiting for frame_done
// SNAP     | snapshot held, X divide started
// DIV_X    | dividing sum_x by count
// DIV_Y    | dividing sum_y by count
// PUB      | outputs updated, result_valid high
module hand_centroid_tracker
   import hand_track_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pixel_in,
   input  logic               valid_in,
   input  logic               frame_done,
   output logic [COORD_W-1:0] centroid_x,
   output logic [COORD_W-1:0] centroid_y,
   output logic [CNT_W-1:0]   pixel_count,
   output logic               hand_present,
   output logic               result_valid,
   output logic               overrun
`ifdef HAND_BBOX_EN
   ,
   output logic [COORD_W-1:0] bbox_xmin,
   output logic [COORD_W-1:0] bbox_xmax,
   output logic [COORD_W-1:0] bbox_ymin,
   output logic [COORD_W-1:0] bbox_ymax
`endif
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

   logic [COORD_W-1:0] x_pos, y_pos;
   logic               hit;
   logic               snap_take;
   logic [CNT_W-1:0]   acc_cnt, cnt_nxt, snap_cnt;
   logic [SUM_W-1:0]   acc_sx, sx_nxt, snap_sx;
   logic [SUM_W-1:0]   acc_sy, sy_nxt, snap_sy;
   logic [2:0]         state, state_nxt;
   logic [COORD_W-1:0] quot_x;
   logic               div_start, div_done;
   logic [SUM_W-1:0]   div_dividend, div_q;

   assign hit       = valid_in & pixel_in;
   assign snap_take = frame_done && (state == ST_IDLE);

   // Running totals including the current pixel, so a pixel coincident with
   // frame_done lands in the ending frame's snapshot.
   always_comb begin
      cnt_nxt = acc_cnt + CNT_W'(hit);
      sx_nxt  = acc_sx + (hit ? SUM_W'(x_pos) : '0);
      sy_nxt  = acc_sy + (hit ? SUM_W'(y_pos) : '0);
   end

   // Raster position: x wraps into y, y saturates on the last line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_pos <= '0;
         y_pos <= '0;
      end else if (frame_done) begin
         x_pos <= '0;
         y_pos <= '0;
      end else if (valid_in) begin
         if (x_pos == X_LAST) begin
            x_pos <= '0;
            if (y_pos != Y_LAST)
               y_pos <= y_pos + COORD_W'(1);
         end else begin
            x_pos <= x_pos + COORD_W'(1);
         end
      end
   end

   // Accumulators restart every frame, even when the snapshot is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt <= '0;
         acc_sx  <= '0;
         acc_sy  <= '0;
      end else if (frame_done) begin
         acc_cnt <= '0;
         acc_sx  <= '0;
         acc_sy  <= '0;
      end else begin
         acc_cnt <= cnt_nxt;
         acc_sx  <= sx_nxt;
         acc_sy  <= sy_nxt;
      end
   end

   // Snapshot only when idle; overrun flags a frame_done that could not be taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_cnt <= '0;
         snap_sx  <= '0;
         snap_sy  <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= frame_done && (state != ST_IDLE);
         if (snap_take) begin
            snap_cnt <= cnt_nxt;
            snap_sx  <= sx_nxt;
            snap_sy  <= sy_nxt;
         end
      end
   end

   // Next-state logic; divider completion paces both divide states.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (frame_done) state_nxt = ST_SNAP;
         ST_SNAP:  state_nxt = ST_DIV_X;
         ST_DIV_X: if (div_done) state_nxt = ST_DIV_Y;
         ST_DIV_Y: if (div_done) state_nxt = ST_PUB;
         ST_PUB:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Single divider shared: X starts in SNAP, Y starts as X completes.
   always_comb begin
      div_start    = (state == ST_SNAP) || ((state == ST_DIV_X) && div_done);
      div_dividend = (state == ST_SNAP) ? snap_sx : snap_sy;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   seq_divider #(
      .DVD_W (SUM_W),
      .DVS_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (snap_cnt),
      .quotient (div_q),
      .done     (div_done)
   );

   // Hold the X quotient until Y completes; publish everything together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quot_x       <= '0;
         centroid_x   <= '0;
         centroid_y   <= '0;
         pixel_count  <= '0;
         hand_present <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if ((state == ST_DIV_X) && div_done)
            quot_x <= to_coord(div_q);
         if ((state == ST_DIV_Y) && div_done) begin
            result_valid <= 1'b1;
            pixel_count  <= snap_cnt;
            hand_present <= (snap_cnt >= CNT_W'(MIN_PIXELS));
            if (snap_cnt == '0) begin
               centroid_x <= '0;
               centroid_y <= '0;
            end else begin
               centroid_x <= quot_x;
               centroid_y <= to_coord(div_q);
            end
         end
      end
   end

`ifdef HAND_BBOX_EN
   logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
   logic [COORD_W-1:0] bx_min_nxt, bx_max_nxt, by_min_nxt, by_max_nxt;
   logic [COORD_W-1:0] sbx_min, sbx_max, sby_min, sby_max;

   // Extents including the current pixel.
   always_comb begin
      bx_min_nxt = (hit && (x_pos < bx_min)) ? x_pos : bx_min;
      bx_max_nxt = (hit && (x_pos > bx_max)) ? x_pos : bx_max;
      by_min_nxt = (hit && (y_pos < by_min)) ? y_pos : by_min;
      by_max_nxt = (hit && (y_pos > by_max)) ? y_pos : by_max;
   end

   // Extent trackers restart each frame; snapshot follows the count snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bx_min  <= '1;
         bx_max  <= '0;
         by_min  <= '1;
         by_max  <= '0;
         sbx_min <= '1;
         sbx_max <= '0;
         sby_min <= '1;
         sby_max <= '0;
      end else begin
         if (frame_done) begin
            bx_min <= '1;
            bx_max <= '0;
            by_min <= '1;
            by_max <= '0;
         end else begin
            bx_min <= bx_min_nxt;
            bx_max <= bx_max_nxt;
            by_min <= by_min_nxt;
            by_max <= by_max_nxt;
         end
         if (snap_take) begin
            sbx_min <= bx_min_nxt;
            sbx_max <= bx_max_nxt;
            sby_min <= by_min_nxt;
            sby_max <= by_max_nxt;
         end
      end
   end

   // Bounding box publishes alongside the centroid; empty frames report zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bbox_xmin <= '1;
         bbox_xmax <= '0;
         bbox_ymin <= '1;
         bbox_ymax <= '0;
      end else if ((state == ST_DIV_Y) && div_done) begin
         if (snap_cnt == '0) begin
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
         end else begin
            bbox_xmin <= sbx_min;
            bbox_xmax <= sbx_max;
            bbox_ymin <= sby_min;
            bbox_ymax <= sby_max;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hand_centroid_tracker.sv
// Scoreboard bench for hand_centroid_tracker on a reduced 64x40 raster.
module tb_hand_centroid_tracker;
   import hand_track_pkg::*;

   localparam int H    = 64;
   localparam int V    = 40;
   localparam int MINP = 50;
   localparam int LAT  = 2 * SUM_W + 4;

   logic               clk, rst_n, pixel_in, valid_in, frame_done;
   logic [COORD_W-1:0] centroid_x, centroid_y;
   logic [CNT_W-1:0]   pixel_count;
   logic               hand_present, result_valid, overrun;
`ifdef HAND_BBOX_EN
   logic [COORD_W-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`endif

   hand_centroid_tracker #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .MIN_PIXELS (MINP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pixel_in     (pixel_in),
      .valid_in     (valid_in),
      .frame_done   (frame_done),
      .centroid_x   (centroid_x),
      .centroid_y   (centroid_y),
      .pixel_count  (pixel_count),
      .hand_present (hand_present),
      .result_valid (result_valid),
      .overrun      (overrun)
`ifdef HAND_BBOX_EN
      ,
      .bbox_xmin    (bbox_xmin),
      .bbox_xmax    (bbox_xmax),
      .bbox_ymin    (bbox_ymin),
      .bbox_ymax    (bbox_ymax)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     cnt;
      longint sx;
      longint sy;
      int     xmin, xmax, ymin, ymax;
      int     due;
   } exp_t;

   exp_t   sb[$];
   exp_t   e;
   int     total = 0;
   int     bad = 0;

   int     mx = 0, my = 0, mcnt = 0;
   longint msx = 0, msy = 0;
   int     mxmin = 1 << 30, mxmax = -1, mymin = 1 << 30, mymax = -1;
   int     last_acc = -1000;
   int     exp_ovr = 0, ovr_seen = 0, ovr_due = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic model_clear();
      mcnt = 0; msx = 0; msy = 0;
      mxmin = 1 << 30; mxmax = -1; mymin = 1 << 30; mymax = -1;
      mx = 0; my = 0;
   endtask

   // One input cycle; the reference model follows the raster and frame rules.
   task automatic drive(input bit v, input bit p, input bit fd);
      exp_t n;
      @(negedge clk);
      valid_in = v; pixel_in = p; frame_done = fd;
      if (v && p) begin
         mcnt++; msx += mx; msy += my;
         if (mx < mxmin) mxmin = mx;
         if (mx > mxmax) mxmax = mx;
         if (my < mymin) mymin = my;
         if (my > mymax) mymax = my;
      end
      if (fd) begin
         if (cyc - last_acc >= LAT + 1) begin
            n.cnt = mcnt; n.sx = msx; n.sy = msy;
            n.xmin = mxmin; n.xmax = mxmax; n.ymin = mymin; n.ymax = mymax;
            n.due = cyc + LAT;
            sb.push_back(n);
            last_acc = cyc;
         end else begin
            exp_ovr++;
            ovr_due = cyc + 1;
         end
         model_clear();
      end else if (v) begin
         if (mx == H - 1) begin
            mx = 0;
            if (my != V - 1) my++;
         end else begin
            mx++;
         end
      end
   endtask

   function automatic bit pix(input int mode, input int x, input int y);
      case (mode)
         0: pix = (x == 10) && (y == 5);
         1: pix = (x >= 20) && (x <= 29) && (y >= 10) && (y <= 19);
         3: pix = ($urandom_range(3) == 0);
         4: pix = (x == H - 1) && (y == V - 1);
         5: pix = ($urandom_range(63) == 0);
         default: pix = 1'b0;
      endcase
   endfunction

   task automatic frame(input int mode, input int rows, input bit fd_last);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < H; c++) begin
            if (mode == 3 && $urandom_range(7) == 0) drive(1'b0, 1'b1, 1'b0);
            drive(1'b1, pix(mode, mx, my), fd_last && (r == rows - 1) && (c == H - 1));
         end
      end
      if (!fd_last) drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // Output monitor: pops the scoreboard on each result.
   always @(negedge clk) begin
      if (rst_n) begin
         if (result_valid) begin
            if (sb.size() == 0) begin
               check("spurious_result", 64'(result_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("latency", 64'(cyc), 64'(e.due));
               check("centroid_x", 64'(centroid_x), (e.cnt == 0) ? 64'd0 : 64'(e.sx / e.cnt));
               check("centroid_y", 64'(centroid_y), (e.cnt == 0) ? 64'd0 : 64'(e.sy / e.cnt));
               check("pixel_count", 64'(pixel_count), 64'(e.cnt));
               check("hand_present", 64'(hand_present), 64'(e.cnt >= MINP));
`ifdef HAND_BBOX_EN
               check("bbox_xmin", 64'(bbox_xmin), (e.cnt == 0) ? 64'd0 : 64'(e.xmin));
               check("bbox_xmax", 64'(bbox_xmax), (e.cnt == 0) ? 64'd0 : 64'(e.xmax));
               check("bbox_ymin", 64'(bbox_ymin), (e.cnt == 0) ? 64'd0 : 64'(e.ymin));
               check("bbox_ymax", 64'(bbox_ymax), (e.cnt == 0) ? 64'd0 : 64'(e.ymax));
`endif
            end
         end
         if (overrun) begin
            ovr_seen++;
            check("overrun_cycle", 64'(cyc), 64'(ovr_due));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; pixel_in = 1'b0; valid_in = 1'b0; frame_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_centroid_x", 64'(centroid_x), 64'd0);
      check("rst_centroid_y", 64'(centroid_y), 64'd0);
      check("rst_pixel_count", 64'(pixel_count), 64'd0);
      check("rst_hand_present", 64'(hand_present), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
`ifdef HAND_BBOX_EN
      check("rst_bbox_xmin", 64'(bbox_xmin), 64'd1023);
      check("rst_bbox_xmax", 64'(bbox_xmax), 64'd0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      frame(0, 6, 1'b0);           // single pixel (10,5)
      wait_drain();
      frame(1, 20, 1'b0);          // 10x10 square -> (24,14), count 100
      wait_drain();
      frame(2, 3, 1'b0);           // empty frame
      wait_drain();

      frame(0, 6, 1'b0);           // accepted frame, then a dropped one
      drive(1'b1, 1'b1, 1'b0);
      repeat (17) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      wait_drain();
      check("hold_pixel_count", 64'(pixel_count), 64'd1);
      frame(0, 6, 1'b0);           // dropped frame's pixel must not leak in
      wait_drain();

      frame(4, V, 1'b1);           // last corner pixel coincident with frame_done
      wait_drain();
      frame(0, 6, 1'b0);
      wait_drain();

      frame(3, V + 4, 1'b0);       // random with gaps, y saturates
      wait_drain();
      frame(5, 3, 1'b0);           // sparse, below threshold
      wait_drain();

      frame(1, 20, 1'b0);          // reset while dividing Y
      while (cyc < last_acc + 45) drive(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_centroid_x", 64'(centroid_x), 64'd0);
      check("abort_pixel_count", 64'(pixel_count), 64'd0);
      check("abort_hand_present", 64'(hand_present), 64'd0);
      sb.delete();
      last_acc = -1000;
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) drive(1'b0, 1'b0, 1'b0);
      frame(1, 20, 1'b0);
      wait_drain();

      check("overrun_total", 64'(ovr_seen), 64'(exp_ovr));
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
